// File: rtl/apb_req_master.sv
// apb_req_master: single-outstanding APB3/APB4 initiator.
// Accepts one valid/ready request, runs an APB SETUP/ACCESS transfer,
// and returns the captured read data and error on a valid/ready
// response channel.
//
// Handshake rule (both channels): a transfer happens on the rising edge
// where valid and ready are both high; a producer holds its payload
// stable while valid is high and ready is low.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to enable the ACCESS
// watchdog (TIMEOUT cycles without out_pready ends the transfer with
// rsp_err=1 and rsp_rdata=0). Without the macro, ACCESS waits forever.
module apb_req_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    // core-side request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_prot,
    // core-side response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // APB requester side
    output logic [31:0] out_paddr,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    output logic        out_psel,
    output logic        out_penable,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    // FSM state for observation
    output logic [1:0]  dbg_state
);

    // The watchdog counter is 16 bits, so TIMEOUT must fit in it.
    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("apb_req_master: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic [2:0]  pprot_q, pprot_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    // Last count value before the watchdog fires: the ACCESS cycle that
    // sees cnt_q at this value with no pready is the TIMEOUT-th idle one.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    // Next-state, capture and watchdog logic.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    // APB4: strobes must be all-zero on reads.
                    pstrb_d  = req_write ? req_wstrb : 4'b0000;
                    pprot_d  = req_prot;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
            end
            S_ACCESS: begin
                // pready has priority over a watchdog expiring in the same cycle.
                if (out_pready) begin
                    rdata_d = pwrite_q ? 32'd0 : out_prdata;
                    err_d   = out_pslverr;
                    state_d = S_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            paddr_q  <= 32'd0;
            pwrite_q <= 1'b0;
            pwdata_q <= 32'd0;
            pstrb_q  <= 4'd0;
            pprot_q  <= 3'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q    <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pprot_q  <= pprot_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // req_ready is masked by reset so it reads 0 while reset is held
    // and rises as soon as reset is released.
    assign req_ready   = (state_q == S_IDLE) && !reset;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign out_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign out_penable = (state_q == S_ACCESS);
    assign out_paddr   = paddr_q;
    assign out_pwrite  = pwrite_q;
    assign out_pwdata  = pwdata_q;
    assign out_pstrb   = pstrb_q;
    assign out_pprot   = pprot_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Testbench for apb_req_master: directed and randomized APB transfers,
// checked cycle by cycle against timing and response rules derived from
// the transfer description. Timeout scenarios run when
// APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_req_master;

  localparam int unsigned TO = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] out_paddr;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic [2:0]  out_pprot;
  logic        out_psel;
  logic        out_penable;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;
  logic [1:0]  dbg_state;

  apb_req_master #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .out_paddr(out_paddr), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pprot(out_pprot), .out_psel(out_psel),
    .out_penable(out_penable), .out_pready(out_pready),
    .out_prdata(out_prdata), .out_pslverr(out_pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [32:0] exp_q[$];  // {err, rdata} per accepted request, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference response: timeout -> error with zero data; write -> zero
  // data; read -> sampled prdata. Error follows pslverr.
  function automatic logic [32:0] model_rsp(input bit wr, input logic [31:0] prdata,
                                            input bit slverr, input bit timed_out);
    if (timed_out) return {1'b1, 32'h0};
    return {slverr, (wr ? 32'h0 : prdata)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bus(input string ph, input logic [31:0] addr, input bit wr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot);
    check({ph, "_paddr"}, out_paddr, addr);
    check({ph, "_pwrite"}, 32'(out_pwrite), 32'(wr));
    check({ph, "_pwdata"}, out_pwdata, wdata);
    check({ph, "_pstrb"}, 32'(out_pstrb), 32'(wr ? strb : 4'b0000));
    check({ph, "_pprot"}, 32'(out_pprot), 32'(prot));
  endtask

  // ---------------- driver ----------------
  // One complete transfer starting in an IDLE cycle. n_access = number of
  // ACCESS cycles; give_pready=0 means the responder never answers.
  task automatic run_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input int n_access, input bit give_pready,
                          input logic [31:0] prdata, input bit slverr,
                          input int rsp_delay, input bit hold_valid);
    logic [32:0] exp;
    bit last;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_psel", 32'(out_psel), 32'd0);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    req_wstrb = strb;
    req_prot  = prot;
    exp_q.push_back(model_rsp(wr, prdata, slverr, !give_pready));
    tick();
    // SETUP: pready here must be ignored
    req_valid   = 1'b0;
    out_pready  = 1'($urandom_range(0, 1));
    out_prdata  = $urandom;
    out_pslverr = 1'($urandom_range(0, 1));
    check("setup_psel", 32'(out_psel), 32'd1);
    check("setup_penable", 32'(out_penable), 32'd0);
    check("setup_req_ready", 32'(req_ready), 32'd0);
    check("setup_rsp_valid", 32'(rsp_valid), 32'd0);
    check_bus("setup", addr, wr, wdata, strb, prot);
    tick();
    for (int i = 0; i < n_access; i++) begin
      check("access_psel", 32'(out_psel), 32'd1);
      check("access_penable", 32'(out_penable), 32'd1);
      check("access_req_ready", 32'(req_ready), 32'd0);
      check("access_rsp_valid", 32'(rsp_valid), 32'd0);
      check_bus("access", addr, wr, wdata, strb, prot);
      last = (i == n_access - 1) && give_pready;
      out_pready  = last;
      out_prdata  = last ? prdata : $urandom;
      out_pslverr = last ? slverr : 1'($urandom_range(0, 1));
      tick();
    end
    exp = exp_q.pop_front();
    for (int i = 0; i <= rsp_delay; i++) begin
      out_pready = 1'($urandom_range(0, 1));
      out_prdata = $urandom;
      req_valid  = hold_valid;
      rsp_ready  = (i == rsp_delay);
      check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("resp_rdata", rsp_rdata, exp[31:0]);
      check("resp_err", 32'(rsp_err), 32'(exp[32]));
      check("resp_psel", 32'(out_psel), 32'd0);
      check("resp_penable", 32'(out_penable), 32'd0);
      check("resp_req_ready", 32'(req_ready), 32'd0);
      check("resp_paddr_hold", out_paddr, addr);
      tick();
    end
    rsp_ready  = 1'b0;
    out_pready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_psel", 32'(out_psel), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d;
    bit wr;
    // reset state
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_psel", 32'(out_psel), 32'd0);
    check("rst_penable", 32'(out_penable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check_bus("rst", 32'd0, 1'b0, 32'd0, 4'd0, 3'd0);
    reset = 1'b0;
    #1;
    check("rst_release_req_ready", 32'(req_ready), 32'd1);

    // zero-wait read
    run_xfer(32'hA000_0010, 1'b0, 32'h0, 4'hF, 3'd2, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    // write with 3 wait states
    run_xfer(32'h0000_0400, 1'b1, 32'h1234_5678, 4'b0101, 3'd0, 4, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    // pslverr on a read
    run_xfer(32'h0000_0800, 1'b0, 32'h0, 4'h0, 3'd1, 2, 1'b1, 32'hCAFE_F00D, 1'b1, 0, 1'b0);
    // back-pressure with next request already waiting
    run_xfer(32'h0000_0C00, 1'b0, 32'h0, 4'h0, 3'd0, 1, 1'b1, 32'h5555_AAAA, 1'b0, 5, 1'b1);
    run_xfer(32'h0000_0C00, 1'b0, 32'h0, 4'h0, 3'd0, 1, 1'b1, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    // watchdog fires after TO ACCESS cycles without pready
    run_xfer(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'd0, TO, 1'b0, 32'h1111_2222, 1'b0, 0, 1'b0);
    // pready in the TO-th ACCESS cycle wins
    run_xfer(32'h0000_1004, 1'b0, 32'h0, 4'h0, 3'd0, TO, 1'b1, 32'h3333_4444, 1'b0, 0, 1'b0);
`endif

    // reset during ACCESS abandons the transfer
    req_valid = 1'b1;
    req_addr  = 32'h0000_2000;
    req_write = 1'b0;
    tick();
    req_valid  = 1'b0;
    out_pready = 1'b0;
    tick();
    tick();
    check("mid_access_penable", 32'(out_penable), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_psel", 32'(out_psel), 32'd0);
    check("mid_rst_penable", 32'(out_penable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_release_ready", 32'(req_ready), 32'd1);
    run_xfer(32'h0000_2004, 1'b0, 32'h0, 4'h0, 3'd3, 1, 1'b1, 32'h7777_8888, 1'b0, 0, 1'b0);

    // randomized transfers
    for (int n = 0; n < 24; n++) begin
      a  = $urandom;
      d  = $urandom;
      wr = 1'($urandom_range(0, 1));
      run_xfer(a, wr, d, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               int'($urandom_range(1, 4)), 1'b1, $urandom, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
